// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator. Sends a captured W-bit pattern MSB first,
// repeated reps times with an optional run of idle cycles between repetitions,
// and pulses done for one cycle after the final pattern bit.
module seq_gen #(
   parameter int W  = 4,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  pat,
   input  logic [RW-1:0] reps,
   input  logic [RW-1:0] gap,
   output logic          x,
   output logic          valid,
   output logic          busy,
   output logic          done
);

   localparam int BW = $clog2(W);
   localparam logic [BW-1:0] TOP = BW'(W - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  pat_q;
   logic [RW-1:0] reps_q;
   logic [RW-1:0] gap_q;
   logic [BW-1:0] bit_idx, bit_idx_nx;
   logic [RW-1:0] rep_cnt, rep_cnt_nx;
   logic [RW-1:0] gap_cnt, gap_cnt_nx;
   logic          done_nx;
   logic          accept;
   logic          last_rep;

   assign accept   = (state == IDLE) && start;
   assign last_rep = (rep_cnt == reps_q - RW'(1));

   // Control state and counters; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_idx <= '0;
         rep_cnt <= '0;
         gap_cnt <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_idx <= bit_idx_nx;
         rep_cnt <= rep_cnt_nx;
         gap_cnt <= gap_cnt_nx;
         done    <= done_nx;
      end
   end

   // Transaction parameters are captured only on an accepted start, so input
   // changes during a transmission have no effect.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         pat_q  <= pat;
         reps_q <= (reps == '0) ? RW'(1) : reps;
         gap_q  <= gap;
      end
   end

   // Next-state, counter updates and Moore outputs.
   always_comb begin
      state_nx   = state;
      bit_idx_nx = bit_idx;
      rep_cnt_nx = rep_cnt;
      gap_cnt_nx = gap_cnt;
      done_nx    = 1'b0;
      x          = 1'b0;
      valid      = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = SEND;
               bit_idx_nx = TOP;
               rep_cnt_nx = '0;
            end
         end
         SEND: begin
            x     = pat_q[bit_idx];
            valid = 1'b1;
            busy  = 1'b1;
            if (bit_idx != '0) begin
               bit_idx_nx = bit_idx - BW'(1);
            end else if (last_rep) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else if (gap_q == '0) begin
               // Back-to-back repetition: restart the pattern with no bubble.
               bit_idx_nx = TOP;
               rep_cnt_nx = rep_cnt + RW'(1);
            end else begin
               state_nx   = GAP;
               gap_cnt_nx = gap_q;
               rep_cnt_nx = rep_cnt + RW'(1);
            end
         end
         GAP: begin
            busy       = 1'b1;
            gap_cnt_nx = gap_cnt - RW'(1);
            if (gap_cnt <= RW'(1)) begin
               state_nx   = SEND;
               bit_idx_nx = TOP;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: table-driven bench for seq_gen with a per-cycle scoreboard of
// expected {x, valid, busy, done}, plus hand-written corner-case sequences.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] pat;
   logic [3:0] reps;
   logic [3:0] gap;
   logic       x, valid, busy, done;

   seq_gen #(.W(4), .RW(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .pat   (pat),
      .reps  (reps),
      .gap   (gap),
      .x     (x),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] pat;
      logic [3:0] reps;
      logic [3:0] gap;
      int         busy_cycles;
   } vec_t;

   logic [3:0] q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         busy_cnt = 0;
   int         cyc = 0;
   bit         mon_en = 1'b0;
   string      cur_name = "reset";

   // Per-cycle scoreboard: empty queue means the DUT must be idle.
   always @(negedge clk) begin
      logic [3:0] exp_v;
      logic [3:0] got_v;
      cyc++;
      if (mon_en) begin
         exp_v = (q.size() > 0) ? q.pop_front() : 4'b0000;
         got_v = {x, valid, busy, done};
         n_vec++;
         if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got x/valid/busy/done=%b, want %b",
                     cur_name, cyc, got_v, exp_v);
         end
         if (busy === 1'b1) busy_cnt++;
      end
   end

   // Reference stream for one transaction, starting with the first SEND cycle.
   task automatic push_model(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
      int rr;
      rr = (r == 4'd0) ? 1 : int'(r);
      for (int i = 0; i < rr; i++) begin
         for (int b = 3; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
         if (i < rr - 1)
            for (int k = 0; k < int'(g); k++) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
   endtask

   // Called at posedge+1; start is accepted at the next edge.
   task automatic send(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
      start = 1'b1;
      pat   = p;
      reps  = r;
      gap   = g;
      @(posedge clk); #1;
      start    = 1'b0;
      busy_cnt = 0;
      push_model(p, r, g);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL %s drain timeout: %0d expected cycles left, want 0", cur_name, q.size());
         q.delete();
      end
   endtask

   task automatic check_busy(input int want);
      n_vec++;
      if (busy_cnt != want) begin
         n_bad++;
         $display("FAIL %s busy cycles: got %0d, want %0d", cur_name, busy_cnt, want);
      end
   endtask

   vec_t vecs[8];

   initial begin
      int n;
      vecs[0] = '{"single",      4'b1011, 4'd1,  4'd0,  4};
      vecs[1] = '{"b2b",         4'b1011, 4'd2,  4'd0,  8};
      vecs[2] = '{"gap3",        4'b1011, 4'd2,  4'd3,  11};
      vecs[3] = '{"reps0",       4'b1100, 4'd0,  4'd0,  4};
      vecs[4] = '{"r3g1",        4'b0110, 4'd3,  4'd1,  14};
      vecs[5] = '{"r4g2",        4'b1111, 4'd4,  4'd2,  22};
      vecs[6] = '{"r15",         4'b0001, 4'd15, 4'd0,  60};
      vecs[7] = '{"gap15",       4'b1000, 4'd2,  4'd15, 23};

      rst = 1'b1; start = 1'b0; pat = '0; reps = '0; gap = '0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      start  = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         cur_name = vecs[i].name;
         send(vecs[i].pat, vecs[i].reps, vecs[i].gap);
         drain();
         check_busy(vecs[i].busy_cycles);
         @(posedge clk); #1;
      end

      // Start and input changes during SEND are ignored.
      cur_name = "busy_start";
      send(4'b1100, 4'd0, 4'd0);
      @(posedge clk); #1;
      start = 1'b1; pat = 4'b0000; reps = 4'd5; gap = 4'd2;
      @(posedge clk); #1;
      start = 1'b0; pat = 4'b1111;
      drain();
      check_busy(4);
      @(posedge clk); #1;

      // Start asserted in the done cycle is accepted.
      cur_name = "start_in_done";
      send(4'b1011, 4'd1, 4'd0);
      n = 0;
      while (q.size() > 1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      send(4'b0110, 4'd1, 4'd0);
      drain();
      @(posedge clk); #1;

      // Reset in cycle 2 of a reps=3 transaction, with start held during reset.
      cur_name = "mid_reset";
      send(4'b1010, 4'd3, 4'd0);
      while (q.size() > 2) void'(q.pop_back());
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1; pat = 4'b1111; reps = 4'd1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // Recovery after reset.
      cur_name = "after_reset";
      send(4'b1001, 4'd2, 4'd1);
      drain();
      check_busy(9);
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter W, default 4, pattern width in bits (W >= 2).
REQ-002 SHALL have parameter RW, default 4, width of the repeat and gap fields.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 SHALL have port pat  input  W  pattern to send, transmitted MSB first; captured on accepted start.
REQ-007 SHALL have port reps  input  RW  number of pattern repetitions; captured on accepted start; 0 is treated as 1.
REQ-008 SHALL have port gap  input  RW  idle cycles inserted between repetitions; captured on accepted start.
REQ-009 SHALL have port x  output  1  serial data bit.
REQ-010 SHALL have port valid  output  1  high when x carries a pattern bit.
REQ-011 SHALL have port busy  output  1  high from the first SEND cycle through the last SEND cycle.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SEND and GAP.
REQ-014 SHALL hold captured registers pat_q, reps_q and gap_q, plus these counters:
- bit_idx, width clog2(W);
- rep_cnt, width RW;
- gap_cnt, width RW.
REQ-015 SHALL make start accepted when state is IDLE and start is 1 at a rising edge.
REQ-016 On accepted start, SHALL do all of the following at that edge:
- latch pat, reps (0 becomes 1) and gap;
- set bit_idx = W-1 and rep_cnt = 0;
- enter SEND.
REQ-017 SHALL drive the first pattern bit in the cycle immediately after the accepting edge (latency 1).
REQ-018 In SEND, SHALL drive x = pat_q[bit_idx], valid = 1 and busy = 1.
REQ-019 In a SEND cycle with bit_idx > 0, SHALL decrement bit_idx at the next edge.
REQ-020 In a SEND cycle with bit_idx = 0 that is the last repetition (rep_cnt = reps_q-1), SHALL enter IDLE at the next edge.
REQ-021 In a SEND cycle with bit_idx = 0 that is not the last repetition and gap_q = 0, SHALL do all of the following at the next edge:
- stay in SEND;
- set bit_idx = W-1;
- increment rep_cnt.
This produces back-to-back repetitions with no bubble.
REQ-022 In a SEND cycle with bit_idx = 0 that is not the last repetition and gap_q > 0, SHALL do all of the following at the next edge:
- enter GAP;
- set gap_cnt = gap_q;
- increment rep_cnt.
REQ-023 In GAP, SHALL drive x = 0, valid = 0 and busy = 1.
REQ-024 In GAP, SHALL decrement gap_cnt each cycle.
REQ-025 In a GAP cycle with gap_cnt = 1, SHALL enter SEND with bit_idx = W-1 at the next edge, so exactly gap_q GAP cycles occur.
REQ-026 In IDLE, SHALL drive x = 0, valid = 0 and busy = 0.
REQ-027 SHALL make done a registered signal, high exactly in the single cycle after the final SEND cycle, and low otherwise.
REQ-028 SHALL accept a start asserted in the done cycle, with the first bit driven in the next cycle.
REQ-029 SHALL ignore start while in SEND or GAP, and SHALL leave captured values unaffected by changes on pat, reps or gap during a transmission.
REQ-030 SHALL make each transaction occupy exactly reps_q*W SEND cycles plus (reps_q-1)*gap_q GAP cycles.

Reset
REQ-031 When rst = 1 at an edge, SHALL set state = IDLE, all counters to 0 and done = 0, so that x = 0, valid = 0 and busy = 0 the next cycle.
REQ-032 SHALL give rst priority over start and over any in-progress transmission.
REQ-033 A transmission aborted by reset SHALL produce no done pulse.
REQ-034 SHALL ignore start while rst = 1.

Verification
REQ-035 Single repetition:
- stimulus: pat=1011, reps=1, gap=0, start pulse;
- response: x = 1,0,1,1 over cycles 1-4, valid = 1 and busy = 1 in cycles 1-4;
- response: done = 1 in cycle 5 only.
REQ-036 Back-to-back repetitions:
- stimulus: pat=1011, reps=2, gap=0;
- response: x = 10111011 over 8 consecutive valid cycles;
- response: done in cycle 9.
REQ-037 Repetitions with gap:
- stimulus: pat=1011, reps=2, gap=3;
- response: 1011, then 3 cycles of x = 0 with valid = 0 and busy = 1, then 1011;
- response: done in cycle 12.
REQ-038 Zero reps and busy start:
- stimulus: reps=0, pat=1100;
- response: 1100 is sent once.
- stimulus: start re-asserted with pat=0000 during SEND;
- response: that start is ignored and the output stream is unchanged.
REQ-039 Reset mid-operation:
- stimulus: rst = 1 in cycle 2 of a reps=3 transaction;
- response: the next cycle is IDLE with x = valid = busy = 0;
- response: no done pulse at any later time.
REQ-040 Start in the done cycle:
- stimulus: start asserted in the done cycle with pat=0110;
- response: x = 0,1,1,0 in the four following cycles.
